// File: rtl/ap3216_pkg.sv
// Shared constants and state encoding for the AP3216 I2C responder model.
package ap3216_pkg;

    localparam logic [7:0] REG_SYS_CFG      = 8'h00;
    localparam logic [7:0] REG_ALS_L        = 8'h0C;
    localparam logic [7:0] REG_ALS_H        = 8'h0D;
    localparam logic [7:0] SW_RESET_CODE    = 8'h04;
    localparam logic [6:0] DEV_ADDR_DEFAULT = 7'h1E;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_REG,
        ST_REG_ACK,
        ST_WDATA,
        ST_WDATA_ACK,
        ST_RDATA,
        ST_RDATA_ACK
    } state_e;

endpackage

// File: rtl/ap3216_i2c_responder_filter.sv
// Two-flop synchroniser plus a FILTER_LEN-sample glitch filter for one I2C line,
// with single-cycle rise/fall flags on the filtered level.
module i2c_line_filter #(
    parameter int FILTER_LEN = 3
) (
    input  logic I_clk,
    input  logic I_reset,
    input  logic line_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    localparam int CW = (FILTER_LEN < 2) ? 1 : $clog2(FILTER_LEN + 1);

    logic          sync1_q, sync2_q, filt_q, prev_q;
    logic [CW-1:0] cnt_q;

    // Idle bus level is high, so everything resets to 1 to avoid phantom edges.
    always_ff @(posedge I_clk or negedge I_reset) begin
        if (!I_reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            filt_q  <= 1'b1;
            prev_q  <= 1'b1;
            cnt_q   <= '0;
        end else begin
            sync1_q <= line_i;
            sync2_q <= sync1_q;
            prev_q  <= filt_q;
            if (sync2_q == filt_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CW'(FILTER_LEN - 1)) begin
                filt_q <= sync2_q;
                cnt_q  <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign level_o = filt_q;
    assign rise_o  = filt_q & ~prev_q;
    assign fall_o  = ~filt_q & prev_q;

endmodule

// File: rtl/ap3216_i2c_responder.sv
// AP3216 ambient-light sensor stand-in: I2C target with SYS_CFG, a coherent
// ALS low/high pair and an auto-incrementing register pointer.
module ap3216_i2c_responder
    import ap3216_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR   = DEV_ADDR_DEFAULT,
    parameter int         FILTER_LEN = 3
) (
    input  logic        I_clk,
    input  logic        I_reset,
    input  logic        I_scl,
    input  logic        I_sda,
    output logic        O_sda_oe,
    input  logic [15:0] I_als_data,
    output logic [7:0]  O_sys_cfg,
    output logic        O_busy
);

    logic scl_f, scl_rise, scl_fall;
    logic sda_f, sda_rise, sda_fall;
    logic start, stop;

    i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_scl_filt (
        .I_clk  (I_clk),
        .I_reset(I_reset),
        .line_i (I_scl),
        .level_o(scl_f),
        .rise_o (scl_rise),
        .fall_o (scl_fall)
    );

    i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_sda_filt (
        .I_clk  (I_clk),
        .I_reset(I_reset),
        .line_i (I_sda),
        .level_o(sda_f),
        .rise_o (sda_rise),
        .fall_o (sda_fall)
    );

    assign start = sda_fall & scl_f;
    assign stop  = sda_rise & scl_f;

    state_e      state_q, state_d;
    logic [2:0]  bitcnt_q, bitcnt_d;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  ptr_q, ptr_d;
    logic [7:0]  cfg_q, cfg_d;
    logic [7:0]  shadow_q, shadow_d;
    logic        oe_q, oe_d;
    logic        busy_q, busy_d;
    logic        rw_q, rw_d;
    logic [7:0]  shift_in, rd_byte;
    logic        last_bit, load_rd;

    always_ff @(posedge I_clk or negedge I_reset) begin
        if (!I_reset) begin
            state_q  <= ST_IDLE;
            bitcnt_q <= '0;
            shift_q  <= '0;
            ptr_q    <= '0;
            cfg_q    <= '0;
            shadow_q <= '0;
            oe_q     <= 1'b0;
            busy_q   <= 1'b0;
            rw_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            bitcnt_q <= bitcnt_d;
            shift_q  <= shift_d;
            ptr_q    <= ptr_d;
            cfg_q    <= cfg_d;
            shadow_q <= shadow_d;
            oe_q     <= oe_d;
            busy_q   <= busy_d;
            rw_q     <= rw_d;
        end
    end

    // ALS bytes read as zero while the sensor is disabled.
    always_comb begin
        rd_byte = 8'h00;
        case (ptr_q)
            REG_SYS_CFG: rd_byte = cfg_q;
            REG_ALS_L:   if (cfg_q[0]) rd_byte = I_als_data[7:0];
            REG_ALS_H:   if (cfg_q[0]) rd_byte = shadow_q;
            default:     rd_byte = 8'h00;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        bitcnt_d = bitcnt_q;
        shift_d  = shift_q;
        ptr_d    = ptr_q;
        cfg_d    = cfg_q;
        shadow_d = shadow_q;
        oe_d     = oe_q;
        busy_d   = busy_q;
        rw_d     = rw_q;
        load_rd  = 1'b0;
        shift_in = {shift_q[6:0], sda_f};
        last_bit = (bitcnt_q == 3'd7);

        case (state_q)
            ST_ADDR, ST_REG, ST_WDATA: begin
                if (scl_rise) begin
                    shift_d  = shift_in;
                    bitcnt_d = bitcnt_q + 3'd1;
                    if (last_bit) begin
                        if (state_q == ST_ADDR) begin
                            if (shift_in[7:1] == DEV_ADDR) begin
                                rw_d    = shift_in[0];
                                state_d = ST_ADDR_ACK;
                            end else begin
                                state_d = ST_IDLE;
                            end
                        end else if (state_q == ST_REG) begin
                            ptr_d   = shift_in;
                            state_d = ST_REG_ACK;
                        end else begin
                            if (ptr_q == REG_SYS_CFG) begin
                                if (shift_in == SW_RESET_CODE) begin
                                    cfg_d    = 8'h00;
                                    shadow_d = 8'h00;
                                end else begin
                                    cfg_d = shift_in;
                                end
                            end
                            ptr_d   = ptr_q + 8'd1;
                            state_d = ST_WDATA_ACK;
                        end
                    end
                end
            end
            // First fall after the 8th bit asserts ACK, the next one releases it.
            ST_ADDR_ACK, ST_REG_ACK, ST_WDATA_ACK: begin
                if (scl_fall) begin
                    if (!oe_q) begin
                        oe_d = 1'b1;
                    end else begin
                        oe_d = 1'b0;
                        if (state_q == ST_ADDR_ACK && rw_q) load_rd = 1'b1;
                        else if (state_q == ST_ADDR_ACK)    state_d = ST_REG;
                        else                                state_d = ST_WDATA;
                    end
                end
            end
            ST_RDATA: begin
                if (scl_fall) begin
                    if (last_bit) begin
                        oe_d     = 1'b0;
                        ptr_d    = ptr_q + 8'd1;
                        bitcnt_d = 3'd0;
                        state_d  = ST_RDATA_ACK;
                    end else begin
                        shift_d  = {shift_q[6:0], 1'b0};
                        oe_d     = ~shift_q[6];
                        bitcnt_d = bitcnt_q + 3'd1;
                    end
                end
            end
            ST_RDATA_ACK: begin
                if (scl_rise && sda_f) state_d = ST_IDLE;
                else if (scl_fall)     load_rd = 1'b1;
            end
            default: ;
        endcase

        if (load_rd) begin
            shift_d  = rd_byte;
            oe_d     = ~rd_byte[7];
            bitcnt_d = 3'd0;
            state_d  = ST_RDATA;
            if (ptr_q == REG_ALS_L) shadow_d = I_als_data[15:8];
        end

        // Bus conditions win over anything the byte logic decided this cycle.
        if (start || stop) begin
            cfg_d    = cfg_q;
            shadow_d = shadow_q;
            ptr_d    = ptr_q;
            oe_d     = 1'b0;
            bitcnt_d = 3'd0;
            busy_d   = start;
            state_d  = start ? ST_ADDR : ST_IDLE;
        end
    end

    assign O_sda_oe  = oe_q;
    assign O_sys_cfg = cfg_q;
    assign O_busy    = busy_q;

endmodule

// File: doc/ap3216_i2c_responder.md
# ap3216_i2c_responder

I2C target (responder) that emulates the AP3216 ambient-light sensor on the board-level SCL/SDA pair, answering the existing AP3216 I2C master. It holds a small register file with system configuration, a readable ALS data pair sourced from a port, and pointer auto-increment. It is used as a bench model and as an on-FPGA stand-in when the sensor is absent.

## Interface
- DEV_ADDR, 7'h1E: 7-bit target address.
- FILTER_LEN, 3: consecutive identical synchronised samples required before an SCL/SDA level change is accepted.
- I_clk  in  1  system clock (50 MHz); ≥ 8× SCL rate required.
- I_reset  in  1  asynchronous, active-low reset.
- I_scl  in  1  SCL line level.
- I_sda  in  1  SDA line level.
- O_sda_oe  out  1  1 = pull SDA low; 0 = release (open drain, external pull-up).
- I_als_data  in  16  live ALS count from the light source model.
- O_sys_cfg  out  8  current SYS_CFG register.
- O_busy  out  1  1 between an accepted START and the following STOP.

## Operation
- Input path: 2-FF synchroniser per line, then glitch filter of FILTER_LEN cycles; filtered scl_f/sda_f drive everything else. Edge flags (scl_rise, scl_fall) are single-cycle.
- START: sda_f falls while scl_f = 1. STOP: sda_f rises while scl_f = 1. Both are recognised in every state and override the current state; STOP → IDLE, START/repeated START → ADDR with bit counter cleared.
- States: IDLE, ADDR, ADDR_ACK, REG, REG_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK.
- ADDR: shift 8 bits MSB first on scl_rise. Address match → ADDR_ACK (drive ACK); R/W = 1 → RDATA, 0 → REG. Mismatch → IDLE, SDA never driven.
- REG: 8 bits into the register pointer → REG_ACK → WDATA.
- WDATA: 8 bits; on the 8th bit write the byte to the pointed register, pointer += 1 (8-bit wrap 0xFF → 0x00), → WDATA_ACK → WDATA. Every byte is ACKed, including writes to read-only or unmapped addresses.
- RDATA: drive bits of the pointed register MSB first; after 8 bits release SDA, pointer += 1, → RDATA_ACK. Sample master ACK on scl_rise: ACK (0) → RDATA with next byte; NACK (1) → IDLE (release, await STOP).
- Register map: 0x00 SYS_CFG RW, reset 0x00. 0x0C ALS_L RO. 0x0D ALS_H RO. All others read 0x00, writes are ignored.
- ALS coherency: reading 0x0C returns I_als_data[7:0] and latches I_als_data[15:8] into a shadow. Reading 0x0D returns the shadow. If SYS_CFG[0] = 0 (ALS disabled), both read 0x00.
- Writing SYS_CFG = 0x04 (SW reset) clears SYS_CFG to 0x00 and the shadow to 0x00 at the end of that byte. The byte is still ACKed.

## Timing
- Reset values: O_sda_oe = 0, O_sys_cfg = 0x00, O_busy = 0, state IDLE, pointer 0x00, shadow 0x00, filter outputs 1.
- Filter latency: 2 + FILTER_LEN cycles from pad to scl_f/sda_f.
- SDA changes (ACK assert, data bit, release) happen exactly 1 cycle after scl_fall. The line is never changed while scl_f = 1, except when a START/STOP forces release.
- ACK is held from scl_fall after bit 8 until the next scl_fall.
- Input bits and the master ACK are sampled on scl_rise.
- O_busy goes to 1 the cycle after START detection and to 0 the cycle after STOP detection.
- Register write lands 1 cycle after the 8th scl_rise. The read byte is loaded into the shift register at the scl_fall that ends the preceding ACK.
- Asynchronous reset mid-transfer releases SDA immediately and returns all state to reset values.

## Structure
- Shared package ap3216_pkg: register address constants (REG_SYS_CFG = 8'h00, REG_ALS_L = 8'h0C, REG_ALS_H = 8'h0D), SW reset code 8'h04, DEV_ADDR default, state encoding.
- One sub-module: i2c_line_filter (synchroniser + glitch filter + edge flags), instantiated twice.
- FSM, shift register, pointer and register file stay in the top.

## Test plan
- Write 0x00 ← 0x01 to address 0x1E → three ACKs, O_sys_cfg = 0x01, O_busy 1 then 0 after STOP.
- SYS_CFG = 0x01, I_als_data = 0xA5C3; write pointer 0x0C, repeated START, read 2 bytes, ACK then NACK → bytes 0xC3, 0xA5. Changing I_als_data to 0x1234 between the two bytes still returns 0xA5.
- SYS_CFG = 0x00, read 0x0C/0x0D → 0x00, 0x00.
- Address 0x1F → no ACK, O_sda_oe stays 0 for the whole transfer.
- 1-cycle glitch on SCL mid-byte with FILTER_LEN = 3 → ignored, byte decoded correctly. STOP inserted mid-byte → IDLE, no register change.
- Write 0x04 to 0x00 after SYS_CFG = 0x01 → O_sys_cfg = 0x00. Assert I_reset during RDATA → O_sda_oe = 0 the same cycle.
